// File: rtl/psum_drain.sv
// psum_drain: reads accumulated partial sums row by row from PSUM SRAM,
// requantizes every lane to OUT_W-bit signed, and streams rows out over a
// valid/ready handshake. A 2-entry skid FIFO covers the SRAM read latency.
module psum_drain #(
  parameter int ADR_P  = 11,
  parameter int SRAM_P = 32,
  parameter int LANES  = 32,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [16:0]              nb_elements,
  input  logic [4:0]               shift,
  input  logic                     relu_en,
  output logic [ADR_P-1:0]         p_sram_addr,
  output logic                     p_sram_rden,
  input  logic [LANES*SRAM_P-1:0]  p_sram_data_i,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_W = LANES * OUT_W;
  localparam logic signed [SRAM_P:0] SAT_MAX = (SRAM_P+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [SRAM_P:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [16:0]        nb_q, rd_cnt_q, wr_cnt_q;
  logic [4:0]         shift_q;
  logic               relu_q;
  logic               inflight_q, inflight_last_q;
  logic [ROW_W-1:0]   fifo_data_q [2];
  logic               fifo_last_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;
  logic               issue, pop, push, room;
  logic [ROW_W-1:0]   rq_row;

  // Rounding shift in SRAM_P+1 bits (so the rounding add cannot wrap),
  // optional ReLU, then saturation to the output range.
  function automatic logic [OUT_W-1:0] requant(input logic [SRAM_P-1:0] v,
                                               input logic [4:0] sh,
                                               input logic relu);
    logic signed [SRAM_P:0] acc;
    acc = {v[SRAM_P-1], v};
    if (sh != 5'd0) acc = acc + ((SRAM_P+1)'(1) << (sh - 5'd1));
    acc = acc >>> sh;
    if (relu && acc[SRAM_P]) acc = '0;
    if (acc > SAT_MAX) acc = SAT_MAX;
    else if (acc < SAT_MIN) acc = SAT_MIN;
    return acc[OUT_W-1:0];
  endfunction

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign rq_row[gi*OUT_W +: OUT_W] =
        requant(p_sram_data_i[gi*SRAM_P +: SRAM_P], shift_q, relu_q);
    end
  endgenerate

  // Handshake and FIFO-space bookkeeping. A new read is allowed only if the
  // row it returns next cycle is guaranteed a free FIFO slot; a full FIFO
  // never issues, even if it pops this cycle.
  always_comb begin
    pop  = (count_q != 2'd0) && out_ready;
    push = inflight_q;
    room = (count_q != 2'd2) &&
           ((count_q + {1'b0, inflight_q} - {1'b0, pop}) < 2'd2);
  end

  // Next-state logic, read issue and status outputs.
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (nb_elements != 17'd0) ? S_READ : S_DONE;
      end
      S_READ: begin
        if ((rd_cnt_q < nb_q) && room) issue = 1'b1;
        if ((issue && (rd_cnt_q + 17'd1 == nb_q)) || (rd_cnt_q == nb_q))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((count_q == 2'd0) && !inflight_q && (wr_cnt_q == nb_q))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    p_sram_rden = issue;
    p_sram_addr = issue ? rd_cnt_q[ADR_P-1:0] : '0;
    busy        = (state_q == S_READ) || (state_q == S_DRAIN);
    done        = (state_q == S_DONE);
    out_valid   = (count_q != 2'd0);
    out_data    = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    out_last    = out_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Configuration latch, row counters and the in-flight read marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      nb_q            <= '0;
      shift_q         <= '0;
      relu_q          <= 1'b0;
      rd_cnt_q        <= '0;
      wr_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start && (nb_elements != 17'd0)) begin
        nb_q     <= nb_elements;
        shift_q  <= shift;
        relu_q   <= relu_en;
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
      end else begin
        if (issue) rd_cnt_q <= rd_cnt_q + 17'd1;
        if (pop)   wr_cnt_q <= wr_cnt_q + 17'd1;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && (rd_cnt_q == nb_q - 17'd1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rq_row;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: expected rows come from an arithmetic
// requant model and are checked by a negedge monitor as the DUT emits them.
module tb_psum_drain;
  localparam int ADR_P = 11, SRAM_P = 32, LANES = 32, OUT_W = 8, ROWS = 64;

  logic                    clk, rst, start, relu_en, out_ready;
  logic [16:0]             nb_elements;
  logic [4:0]              shift;
  logic [ADR_P-1:0]        p_sram_addr;
  logic                    p_sram_rden;
  logic [LANES*SRAM_P-1:0] p_sram_data_i;
  logic [LANES*OUT_W-1:0]  out_data;
  logic                    out_valid, out_last, busy, done;

  psum_drain #(.ADR_P(ADR_P), .SRAM_P(SRAM_P), .LANES(LANES), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .nb_elements(nb_elements),
    .shift(shift), .relu_en(relu_en), .p_sram_addr(p_sram_addr),
    .p_sram_rden(p_sram_rden), .p_sram_data_i(p_sram_data_i),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*OUT_W-1:0] data;
    bit                     last;
  } beat_t;

  int    sram [ROWS][LANES];
  beat_t exp_q[$];
  int    addr_q[$];
  int    cmp_n = 0, err_n = 0, iss_cnt = 0, pop_cnt = 0, done_cnt = 0;
  int    ready_mode = 0, ready_phase = 0;
  bit    have_hold = 0, hold_l, pn;
  logic [LANES*OUT_W-1:0] hold_d;
  beat_t eb;
  int    ea;

  // Registered-read SRAM model.
  always @(posedge clk) begin
    if (p_sram_rden)
      for (int l = 0; l < LANES; l++)
        p_sram_data_i[l*SRAM_P +: SRAM_P] <= sram[int'(p_sram_addr) % ROWS][l];
  end

  task automatic check(input string name, input longint act, input longint req);
    cmp_n++;
    if (act != req) begin
      err_n++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Requant reference: floor((v + half) / 2^sh), ReLU, clamp to int8.
  function automatic int ref_q(input int v, input int sh, input bit relu);
    longint x, d, q;
    x = v;
    d = longint'(1) << sh;
    if (sh > 0) x = x + d / 2;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  // Monitor: read addresses, outstanding rows, stall stability, scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      pn = out_valid && out_ready;
      if (have_hold) begin
        cmp_n++;
        if (!(out_valid && out_data == hold_d && out_last == hold_l)) begin
          err_n++;
          $display("FAIL hold: valid=%0b last=%0b data=%h, expected held last=%0b data=%h",
                   out_valid, out_last, out_data, hold_l, hold_d);
        end
      end
      have_hold = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (p_sram_rden) begin
        if (addr_q.size() == 0) begin
          cmp_n++; err_n++;
          $display("FAIL unexpected_read: addr=%0d, expected no read", p_sram_addr);
        end else begin
          ea = addr_q.pop_front();
          check("addr", p_sram_addr, ea);
        end
        check("outstanding_le2", (iss_cnt - pop_cnt - int'(pn)) <= 1, 1);
        iss_cnt++;
      end
      if (pn) begin
        if (exp_q.size() == 0) begin
          cmp_n++; err_n++;
          $display("FAIL unexpected_beat: data=%h last=%0b, expected none", out_data, out_last);
        end else begin
          eb = exp_q.pop_front();
          cmp_n++;
          if (out_data !== eb.data || out_last !== eb.last) begin
            err_n++;
            $display("FAIL beat: data=%h last=%0b, expected data=%h last=%0b",
                     out_data, out_last, eb.data, eb.last);
          end
        end
        pop_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  // Consumer ready patterns: 0 always ready, 1 repeating 1,0,0, 2 random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = (ready_phase % 3 == 0); ready_phase++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic fill_rows(input int n);
    for (int r = 0; r < n; r++)
      for (int l = 0; l < LANES; l++)
        case ($urandom_range(0, 2))
          0:       sram[r][l] = int'($urandom);
          1:       sram[r][l] = int'($urandom_range(0, 600)) - 300;
          default: sram[r][l] = int'($urandom_range(0, 40000)) - 20000;
        endcase
  endtask

  task automatic push_expected(input int nb, input int sh, input bit relu);
    beat_t b;
    for (int r = 0; r < nb; r++) begin
      for (int l = 0; l < LANES; l++)
        b.data[l*OUT_W +: OUT_W] = 8'(ref_q(sram[r][l], sh, relu));
      b.last = (r == nb - 1);
      exp_q.push_back(b);
      addr_q.push_back(r);
    end
  endtask

  task automatic pulse_start(input int nb, input int sh, input bit relu);
    @(posedge clk); #1;
    start = 1'b1; nb_elements = 17'(nb); shift = 5'(sh); relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_drain(input int nb, input int sh, input bit relu,
                           input int mode, input bit poke);
    int d0, k, gaps, t;
    ready_mode = mode;
    push_expected(nb, sh, relu);
    d0 = done_cnt;
    pulse_start(nb, sh, relu);
    if (nb == 0) begin
      @(negedge clk);
      check("zero_done_lat", done, 1);
      check("zero_busy", busy, 0);
    end else begin
      k = 0;
      while (k < 20) begin
        @(negedge clk);
        if (out_valid) break;
        k++;
      end
      check("first_valid_lat", k, 2);
      if (mode == 0) begin
        gaps = 0;
        for (int j = 1; j < nb; j++) begin
          @(negedge clk);
          if (!out_valid) gaps++;
        end
        check("stream_gaps", gaps, 0);
      end
      if (poke) pulse_start(3, 9, !relu);
    end
    t = 0;
    while (done_cnt == d0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    check("done_once", done_cnt - d0, 1);
    check("sb_empty", exp_q.size(), 0);
    check("reads_empty", addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, p_sram_addr, 0);
    check({tag, "_rden"}, p_sram_rden, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data0"}, out_data == '0, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int d0, t, p0;
    int lane0 [4];
    rst = 1'b1; start = 1'b0; nb_elements = '0; shift = '0; relu_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1 rst = 1'b0;

    // Saturation at shift 0.
    fill_rows(4);
    lane0 = '{10, -20, 300, -300};
    for (int r = 0; r < 4; r++) sram[r][0] = lane0[r];
    run_drain(4, 0, 0, 0, 0);

    // Round half up, including the no-wrap corner.
    fill_rows(4);
    lane0 = '{5, 6, -5, 32'h7FFF_FFFF};
    for (int r = 0; r < 4; r++) sram[r][0] = lane0[r];
    run_drain(4, 1, 0, 0, 0);

    // ReLU.
    fill_rows(2);
    sram[0][0] = -7; sram[1][0] = 50;
    run_drain(2, 0, 1, 0, 0);

    // Backpressure with a start pulse while busy.
    fill_rows(8);
    ready_phase = 0;
    run_drain(8, 4, 0, 1, 1);

    // Empty drain.
    run_drain(0, 3, 0, 0, 0);

    // Randomized drains.
    for (int i = 0; i < 6; i++) begin
      int nb;
      nb = $urandom_range(1, 40);
      fill_rows(nb);
      run_drain(nb, $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Reset mid-drain, then replay.
    fill_rows(8);
    ready_mode = 0;
    push_expected(8, 2, 0);
    d0 = done_cnt;
    p0 = pop_cnt;
    pulse_start(8, 2, 0);
    t = 0;
    while (pop_cnt < p0 + 3 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("beats_before_reset", pop_cnt - p0 >= 3, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    exp_q.delete();
    addr_q.delete();
    have_hold = 0;
    iss_cnt = 0;
    pop_cnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    run_drain(8, 2, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
